interrupt_controller: RTL and testbench

Bus-mapped interrupt controller that sits between the peripherals (Timer, IO_Mouse, IR, and later blocks) and the Processor's interrupt inputs. It captures interrupt requests from up to N sources and holds them in mask/pending registers. It arbitrates between them, fixed-priority or round-robin, and forwards one at a time on a single processor interrupt line. The processor reads the source ID from a vector register and ends service with an end-of-interrupt (EOI) write.

---
 rtl/interrupt_controller_pkg.sv | 22 ++
 rtl/interrupt_controller_if.sv | 35 +++
 rtl/interrupt_controller_irq_rr_pick.sv | 38 +++
 rtl/interrupt_controller.sv | 176 +++++++++++++++++
 tb/tb_interrupt_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// CTRL bit positions and the dispatch FSM state type.
package interrupt_controller_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] OFS_MASK = 2'd0;
  localparam logic [1:0] OFS_PEND = 2'd1;
  localparam logic [1:0] OFS_VEC  = 2'd2;
  localparam logic [1:0] OFS_CTRL = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_RR_BIT = 1;

  // Dispatch FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ACK   = 2'd1,
    IN_SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus and handshake bundle between the controller, the peripherals and the
// processor. The tristate data bus stays a plain port on the controller so
// that its single driver is easy to see at the top level.
interface interrupt_controller_if #(
  parameter int N_SRC = 4
);

  logic [7:0]       bus_addr;
  logic             bus_we;
  logic [N_SRC-1:0] src_raise;
  logic [N_SRC-1:0] src_ack;
  logic             cpu_int_raise;
  logic             cpu_int_ack;

  // Controller side
  modport slave (
    input  bus_addr,
    input  bus_we,
    input  src_raise,
    input  cpu_int_ack,
    output src_ack,
    output cpu_int_raise
  );

  // Bus master / environment side
  modport master (
    output bus_addr,
    output bus_we,
    output src_raise,
    output cpu_int_ack,
    input  src_ack,
    input  cpu_int_raise
  );

endinterface

// File: rtl/interrupt_controller_irq_rr_pick.sv
// Combinational request picker. In fixed mode the search starts at index 0
// (lowest index wins); in round-robin mode it starts at i_start and wraps.
module irq_rr_pick #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [2:0]       i_start,
  input  logic             i_rr,
  output logic             o_valid,
  output logic [2:0]       o_id
);

  logic [7:0] w_req8;
  logic [3:0] w_sum;
  logic [2:0] w_idx;

  assign w_req8 = 8'(i_req);

  // Scan all sources from the start index, keeping the first request found
  always_comb begin
    o_valid = 1'b0;
    o_id    = 3'd0;
    w_sum   = 4'd0;
    w_idx   = 3'd0;
    for (int k = 0; k < N_SRC; k++) begin
      w_sum = (i_rr ? {1'b0, i_start} : 4'd0) + 4'(k);
      if (w_sum >= 4'(N_SRC)) begin
        w_sum = w_sum - 4'(N_SRC);
      end
      w_idx = w_sum[2:0];
      if (!o_valid && w_req8[w_idx]) begin
        o_valid = 1'b1;
        o_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Bus-mapped interrupt controller: captures rising edges of peripheral
// requests into PENDING, arbitrates enabled requests and forwards one at a
// time to the processor, which reads VECTOR and finishes with an EOI write.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = 8'hE8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  inout  wire  [7:0]             io_bus_data,
  interrupt_controller_if.slave  bus
);

  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_src_ack;
  logic [1:0]       r_ctrl;
  logic             r_vec_valid;
  logic [2:0]       r_vec_id;
  logic [2:0]       r_last;
  irq_state_t       r_state;
  logic             r_cpu_int_raise;
  logic             r_rd_en;
  logic [1:0]       r_rd_ofs;

  logic [7:0]       w_addr_diff;
  logic             w_hit;
  logic [1:0]       w_ofs;
  logic             w_wr;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_req;
  logic [2:0]       w_start;
  logic             w_pick_valid;
  logic [2:0]       w_pick_id;
  logic             w_dispatch;
  logic             w_eoi;
  logic [7:0]       w_clr_onehot;
  logic [N_SRC-1:0] w_pend_next;
  logic [7:0]       w_rd_data;
  logic             w_unused;

  // Address decode: offset from BASE_ADDR, hit when the offset is 0..3
  assign w_addr_diff = bus.bus_addr - BASE_ADDR;
  assign w_hit       = (w_addr_diff[7:2] == 6'd0);
  assign w_ofs       = w_addr_diff[1:0];
  assign w_wr        = w_hit && bus.bus_we;
  assign w_unused    = ^io_bus_data;

  // Request capture and arbitration inputs
  assign w_rise  = bus.src_raise & ~r_src_q;
  assign w_req   = r_pend & r_mask;
  assign w_start = (r_last == 3'(N_SRC - 1)) ? 3'd0 : r_last + 3'd1;

  irq_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .i_rr    (r_ctrl[CTRL_RR_BIT]),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  assign w_dispatch   = (r_state == IDLE) && r_ctrl[CTRL_EN_BIT] && w_pick_valid;
  assign w_eoi        = (r_state == IN_SERVICE) && w_wr && (w_ofs == OFS_VEC);
  assign w_clr_onehot = 8'd1 << w_pick_id;

  // Next PENDING: write-1-to-clear and dispatch clear first, new edges win
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr && (w_ofs == OFS_PEND)) begin
      w_pend_next = w_pend_next & ~io_bus_data[N_SRC-1:0];
    end
    if (w_dispatch) begin
      w_pend_next = w_pend_next & ~w_clr_onehot[N_SRC-1:0];
    end
    w_pend_next = w_pend_next | w_rise;
  end

  // Edge capture, acknowledge pulse and PENDING register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_src_q   <= '0;
      r_src_ack <= '0;
      r_pend    <= '0;
    end else begin
      r_src_q   <= bus.src_raise;
      r_src_ack <= w_rise;
      r_pend    <= w_pend_next;
    end
  end

  // MASK and CTRL bus writes
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_mask <= '0;
      r_ctrl <= 2'b00;
    end else if (w_wr) begin
      if (w_ofs == OFS_MASK) begin
        r_mask <= io_bus_data[N_SRC-1:0];
      end
      if (w_ofs == OFS_CTRL) begin
        r_ctrl <= io_bus_data[1:0];
      end
    end
  end

  // Dispatch FSM: raise to the processor, wait for ACK, wait for EOI
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state         <= IDLE;
      r_cpu_int_raise <= 1'b0;
      r_vec_valid     <= 1'b0;
      r_vec_id        <= 3'd0;
      r_last          <= 3'(N_SRC - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_dispatch) begin
            r_vec_valid     <= 1'b1;
            r_vec_id        <= w_pick_id;
            r_last          <= w_pick_id;
            r_cpu_int_raise <= 1'b1;
            r_state         <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.cpu_int_ack) begin
            r_cpu_int_raise <= 1'b0;
            r_state         <= IN_SERVICE;
          end
        end
        IN_SERVICE: begin
          if (w_eoi) begin
            r_vec_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Register the read address match; data goes out during the next cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rd_en  <= 1'b0;
      r_rd_ofs <= 2'd0;
    end else begin
      r_rd_en  <= w_hit && !bus.bus_we;
      r_rd_ofs <= w_ofs;
    end
  end

  // Read data mux over the live register contents
  always_comb begin
    w_rd_data = 8'h00;
    case (r_rd_ofs)
      OFS_MASK: w_rd_data = 8'(r_mask);
      OFS_PEND: w_rd_data = 8'(r_pend);
      OFS_VEC:  w_rd_data = {r_vec_valid, 4'b0000, r_vec_id};
      OFS_CTRL: w_rd_data = {6'b000000, r_ctrl};
      default:  w_rd_data = 8'h00;
    endcase
  end

  assign io_bus_data       = r_rd_en ? w_rd_data : 8'bz;
  assign bus.src_ack       = r_src_ack;
  assign bus.cpu_int_raise = r_cpu_int_raise;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register reset values, capture
// and dispatch latency, fixed and round-robin arbitration, masking,
// PENDING set/clear races, merged edges and reset in WAIT_ACK.
module tb_interrupt_controller;
  import interrupt_controller_pkg::*;

  localparam logic [7:0] BASE = 8'hE8;

  logic       clk = 1'b0;
  logic       resetN;
  wire  [7:0] busData;
  logic       tbDriveEn;
  logic [7:0] tbDriveData;
  int         vectorCount = 0;
  int         missCount = 0;
  logic [7:0] rdVal;

  interrupt_controller_if #(.N_SRC(4)) busIf ();

  always #5 clk = ~clk;

  assign busData = tbDriveEn ? tbDriveData : 8'bz;

  interrupt_controller #(
    .N_SRC     (4),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (resetN),
    .io_bus_data (busData),
    .bus         (busIf)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, actual, expected);
    end
  endtask

  // Drive sources and ACK for one cycle; ACK always drops afterwards
  task automatic applyStimulus(input logic [3:0] src, input logic ack);
    busIf.src_raise   = src;
    busIf.cpu_int_ack = ack;
    @(negedge clk);
    busIf.cpu_int_ack = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] ofs, input logic [7:0] data);
    busIf.bus_addr = BASE + 8'(ofs);
    busIf.bus_we   = 1'b1;
    tbDriveData    = data;
    tbDriveEn      = 1'b1;
    @(negedge clk);
    busIf.bus_we   = 1'b0;
    tbDriveEn      = 1'b0;
    busIf.bus_addr = 8'h00;
  endtask

  // Address phase, data phase, then one idle cycle so drivers never overlap
  task automatic busRead(input logic [1:0] ofs, output logic [7:0] data);
    busIf.bus_addr = BASE + 8'(ofs);
    busIf.bus_we   = 1'b0;
    @(negedge clk);
    data           = busData;
    busIf.bus_addr = 8'h00;
    @(negedge clk);
  endtask

  task automatic checkReg(input string tag, input logic [1:0] ofs, input logic [7:0] expected);
    logic [7:0] v;
    busRead(ofs, v);
    checkOutput(tag, v, expected);
  endtask

  task automatic waitRaise(input string tag);
    int n = 0;
    while (!busIf.cpu_int_raise && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 8'(busIf.cpu_int_raise), 8'h01);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] rrOrder [4];
    rrOrder = '{2'd0, 2'd1, 2'd0, 2'd1};

    resetN            = 1'b0;
    busIf.src_raise   = 4'b0000;
    busIf.cpu_int_ack = 1'b0;
    busIf.bus_addr    = 8'h00;
    busIf.bus_we      = 1'b0;
    tbDriveEn         = 1'b0;
    tbDriveData       = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rstRaise", 8'(busIf.cpu_int_raise), 8'h00);
    checkOutput("rstAck", 8'(busIf.src_ack), 8'h00);
    resetN = 1'b1;
    checkReg("rstMask", OFS_MASK, 8'h00);
    checkReg("rstPend", OFS_PEND, 8'h00);
    checkReg("rstVec", OFS_VEC, 8'h00);
    checkReg("rstCtrl", OFS_CTRL, 8'h00);

    $display("[TB] single source latency");
    busWrite(OFS_CTRL, 8'h01);
    busWrite(OFS_MASK, 8'h0F);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("t1AckPulse", 8'(busIf.src_ack), 8'h04);
    checkOutput("t1RaiseEarly", 8'(busIf.cpu_int_raise), 8'h00);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("t1AckDrop", 8'(busIf.src_ack), 8'h00);
    checkOutput("t1Raise", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t1Vec", OFS_VEC, 8'h82);
    checkReg("t1PendCleared", OFS_PEND, 8'h00);
    busWrite(OFS_VEC, 8'h00);
    checkReg("t1EoiIgnored", OFS_VEC, 8'h82);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("t1RaiseFall", 8'(busIf.cpu_int_raise), 8'h00);
    busWrite(OFS_VEC, 8'h00);
    checkReg("t1VecAfterEoi", OFS_VEC, 8'h02);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] fixed priority");
    applyStimulus(4'b1010, 1'b0);
    checkOutput("t2AckPair", 8'(busIf.src_ack), 8'h0A);
    applyStimulus(4'b1010, 1'b0);
    checkOutput("t2Raise", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t2VecFirst", OFS_VEC, 8'h81);
    applyStimulus(4'b1010, 1'b1);
    busWrite(OFS_VEC, 8'h00);
    checkOutput("t2IdleGap", 8'(busIf.cpu_int_raise), 8'h00);
    applyStimulus(4'b1010, 1'b0);
    checkOutput("t2Raise2", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t2VecSecond", OFS_VEC, 8'h83);
    applyStimulus(4'b1010, 1'b1);
    busWrite(OFS_VEC, 8'h00);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] round robin");
    busWrite(OFS_CTRL, 8'h03);
    applyStimulus(4'b0011, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitRaise("t3Raise");
      checkReg("t3Order", OFS_VEC, 8'h80 | 8'(rrOrder[k]));
      applyStimulus(4'b0011, 1'b1);
      if (k < 3) begin
        applyStimulus(4'b0011 & ~(4'b0001 << rrOrder[k]), 1'b0);
        applyStimulus(4'b0011, 1'b0);
      end else begin
        busWrite(OFS_CTRL, 8'h02);
      end
      busWrite(OFS_VEC, 8'h00);
    end
    busWrite(OFS_PEND, 8'hFF);
    checkReg("t3PendFlushed", OFS_PEND, 8'h00);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] masking");
    busWrite(OFS_CTRL, 8'h01);
    busWrite(OFS_MASK, 8'h00);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t4MaskedRaise", 8'(busIf.cpu_int_raise), 8'h00);
    checkReg("t4PendMasked", OFS_PEND, 8'h01);
    checkOutput("t4StillQuiet", 8'(busIf.cpu_int_raise), 8'h00);
    busWrite(OFS_MASK, 8'h01);
    checkOutput("t4MaskEdge", 8'(busIf.cpu_int_raise), 8'h00);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("t4Unmasked", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t4Vec", OFS_VEC, 8'h80);
    applyStimulus(4'b0001, 1'b1);
    busWrite(OFS_VEC, 8'h00);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] merge and clear races");
    busWrite(OFS_MASK, 8'h00);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("t5Ack1", 8'(busIf.src_ack), 8'h02);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("t5Ack2", 8'(busIf.src_ack), 8'h02);
    checkReg("t5Merged", OFS_PEND, 8'h02);
    busIf.src_raise = 4'b0011;
    busWrite(OFS_PEND, 8'h01);
    checkReg("t5SetWins", OFS_PEND, 8'h03);
    busWrite(OFS_PEND, 8'h01);
    checkReg("t5W1c", OFS_PEND, 8'h02);
    busWrite(OFS_MASK, 8'h02);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("t5Dispatch", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t5Vec", OFS_VEC, 8'h81);
    applyStimulus(4'b0011, 1'b1);
    busWrite(OFS_VEC, 8'h00);
    repeat (3) applyStimulus(4'b0011, 1'b0);
    checkOutput("t5OneDispatch", 8'(busIf.cpu_int_raise), 8'h00);
    checkReg("t5PendEmpty", OFS_PEND, 8'h00);
    applyStimulus(4'b0000, 1'b0);

    $display("[TB] reset during WAIT_ACK");
    busWrite(OFS_MASK, 8'h0F);
    applyStimulus(4'b1100, 1'b0);
    applyStimulus(4'b1100, 1'b0);
    checkOutput("t6Raise", 8'(busIf.cpu_int_raise), 8'h01);
    busWrite(OFS_CTRL, 8'h00);
    checkOutput("t6NoRetract", 8'(busIf.cpu_int_raise), 8'h01);
    checkReg("t6Vec", OFS_VEC, 8'h82);
    busIf.src_raise = 4'b0000;
    resetN = 1'b0;
    @(negedge clk);
    checkOutput("t6RstRaise", 8'(busIf.cpu_int_raise), 8'h00);
    resetN = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t6AckIgnored", 8'(busIf.cpu_int_raise), 8'h00);
    checkReg("t6VecCleared", OFS_VEC, 8'h00);
    checkReg("t6PendLost", OFS_PEND, 8'h00);
    checkReg("t6MaskReset", OFS_MASK, 8'h00);
    checkReg("t6CtrlReset", OFS_CTRL, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
